branch_compare_seq: RTL

- Multi-cycle, parametrised successor of the single-cycle branch comparator.
- Resolves RV32/RV64 branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) by comparing operands CHUNK bits per cycle, MSB chunk first, with early termination.
- Sits between the register-file read stage and the PC-select logic in area-constrained cores.
- Uses a start/busy/done handshake and holds its result for the control FSM.

---
 rtl/branch_compare_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/branch_compare_seq.sv
// Multi-cycle RISC-V branch comparator: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU by
// walking the operands CHUNK bits per cycle from the MSB end, stopping early.
module branch_compare_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic [2:0]      cmp_op,
    output logic            busy,
    output logic            done,
    output logic            jump_condition,
    output logic            illegal_op
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [XLEN-1:0]  MSB_MASK = ~({XLEN{1'b1}} >> 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_CMP
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_op;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_jump;
    logic              r_illegal;

    logic [XLEN-1:0]   w_sign_mask;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic              w_chunk_ne;
    logic              w_chunk_lt;
    logic              w_op_illegal;

    // Flipping both sign bits maps signed order onto unsigned order, so the
    // chunk walk never needs to know whether the op is signed.
    assign w_sign_mask = ((cmp_op == OP_BLT) || (cmp_op == OP_BGE)) ? MSB_MASK : '0;

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_chunk = r_a[XLEN-1-i*CHUNK -: CHUNK];
                w_b_chunk = r_b[XLEN-1-i*CHUNK -: CHUNK];
            end
        end
    end

    assign w_chunk_ne   = (w_a_chunk != w_b_chunk);
    assign w_chunk_lt   = (w_a_chunk <  w_b_chunk);
    assign w_op_illegal = (r_op[2:1] == 2'b01);

    function automatic logic f_jump(input logic [2:0] op, input logic eq, input logic lt);
        logic res;
        case (op)
            OP_BEQ:           res = eq;
            OP_BNE:           res = !eq;
            OP_BLT, OP_BLTU:  res = lt;
            OP_BGE, OP_BGEU:  res = !lt;
            default:          res = 1'b0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_jump    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= rs1_value ^ w_sign_mask;
                        r_b     <= rs2_value ^ w_sign_mask;
                        r_op    <= cmp_op;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_op_illegal) begin
                        r_jump    <= 1'b0;
                        r_illegal <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_chunk_ne) begin
                        r_jump    <= f_jump(r_op, 1'b0, w_chunk_lt);
                        r_illegal <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_idx == LAST_IDX) begin
                        r_jump    <= f_jump(r_op, 1'b1, 1'b0);
                        r_illegal <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign jump_condition = r_jump;
    assign illegal_op     = r_illegal;

endmodule
